// File: rtl/simon_playback_pkg.sv
// Shared Simon definitions: symbol type, playback state encoding, symbol decode
// and the default playback tick constants.
package simon_playback_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_FETCH,
        S_ON,
        S_OFF
    } play_state_e;

    localparam int LEAD_TICKS_DEF = 48;
    localparam int ON_TICKS_DEF   = 48;
    localparam int OFF_TICKS_DEF  = 24;

    // Symbol numbering follows the buttons: 0=BTNU, 1=BTNL, 2=BTNR, 3=BTND.
    function automatic logic [3:0] sym_to_onehot(input sym_t sym);
        return 4'b0001 << sym;
    endfunction

endpackage

// File: rtl/simon_playback_tick_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded
// interval, so loading N yields a phase that lasts exactly N cycles.
module simon_playback_tick_timer #(
    parameter int W = 6
) (
    input  logic         btn_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge btn_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/simon_playback.sv
// Simon sequence playback: fetches symbols from the sequence memory and shows
// each as a one-hot LED pattern for ON_TICKS, followed by an OFF_TICKS gap.
module simon_playback
    import simon_playback_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int LEAD_TICKS = LEAD_TICKS_DEF,
    parameter int ON_TICKS   = ON_TICKS_DEF,
    parameter int OFF_TICKS  = OFF_TICKS_DEF
) (
    input  logic          btn_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   length,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [3:0]    led,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx
);

    localparam int MAX_TICKS = (LEAD_TICKS > ON_TICKS)
                             ? ((LEAD_TICKS > OFF_TICKS) ? LEAD_TICKS : OFF_TICKS)
                             : ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
    // One extra value so the largest tick count itself is representable.
    localparam int TW = $clog2(MAX_TICKS + 1);

    play_state_e   state;
    logic [AW-1:0] idx;
    logic [AW:0]   len_r;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_expire;
    logic          last_sym;

    assign last_sym = ({1'b0, idx} == len_r - 1'b1);
    assign step_idx = idx;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (abort) begin
            tmr_load = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && length != '0) begin
                        tmr_load  = 1'b1;
                        tmr_value = TW'(LEAD_TICKS);
                    end
                end
                S_FETCH: begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(ON_TICKS);
                end
                S_ON: begin
                    if (tmr_expire) begin
                        tmr_load  = 1'b1;
                        tmr_value = TW'(OFF_TICKS);
                    end
                end
                default: ;
            endcase
        end
    end

    simon_playback_tick_timer #(.W(TW)) u_timer (
        .btn_clk (btn_clk),
        .reset   (reset),
        .load    (tmr_load),
        .value   (tmr_value),
        .expire  (tmr_expire)
    );

    always_ff @(posedge btn_clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_addr <= '0;
            idx     <= '0;
            len_r   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                led     <= '0;
                busy    <= 1'b0;
                rd_addr <= '0;
                idx     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                done <= 1'b1;
                            end else begin
                                len_r   <= (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
                                idx     <= '0;
                                rd_addr <= '0;
                                busy    <= 1'b1;
                                state   <= S_LEAD;
                            end
                        end
                    end
                    S_LEAD: begin
                        if (tmr_expire) state <= S_FETCH;
                    end
                    S_FETCH: begin
                        // The LED register is the symbol latch; later rd_data changes are ignored.
                        led   <= sym_to_onehot(sym_t'(rd_data));
                        state <= S_ON;
                    end
                    S_ON: begin
                        if (tmr_expire) begin
                            led   <= '0;
                            state <= S_OFF;
                        end
                    end
                    S_OFF: begin
                        if (tmr_expire) begin
                            if (last_sym) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                idx     <= idx + 1'b1;
                                rd_addr <= idx + 1'b1;
                                state   <= S_FETCH;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_playback.sv
// Self-checking bench for simon_playback: directed scenarios plus random
// sequences, compared cycle by cycle against a slot-arithmetic timeline model.
module tb_simon_playback;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LEAD  = 2;
    localparam int ON    = 3;
    localparam int OFF   = 2;
    localparam int SLOT  = 1 + ON + OFF;

    logic          btn_clk = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [AW:0]   length  = '0;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data = '0;
    logic [3:0]    led;
    logic          busy;
    logic          done;
    logic [AW-1:0] step_idx;

    int checks = 0;
    int errors = 0;

    logic [1:0] mem     [DEPTH];
    logic [1:0] ref_mem [DEPTH];

    simon_playback #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .LEAD_TICKS (LEAD),
        .ON_TICKS   (ON),
        .OFF_TICKS  (OFF)
    ) dut (
        .btn_clk  (btn_clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .length   (length),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    always #5 btn_clk = ~btn_clk;

    // Sequence memory: the address presented after an edge is read out in
    // time for the following edge.
    always @(negedge btn_clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a playback with start sampled at edge 0 and check outputs after
    // every edge up to one cycle past completion. abort_k/dup_k > 0 drive
    // abort/start so they are sampled at that edge.
    task automatic play(input int len, input int abort_k, input int dup_k, input bit scribble);
        int         n;
        int         total;
        int         s;
        int         p;
        logic [3:0] e_led;
        n     = (len > DEPTH) ? DEPTH : len;
        total = (n == 0) ? 0 : LEAD + n * SLOT;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        @(negedge btn_clk);
        start  = 1'b1;
        length = (AW+1)'(len);
        for (int k = 0; k <= total + 1; k++) begin
            @(posedge btn_clk);
            #1;
            if (abort_k > 0 && k == abort_k) begin
                check("abort_busy", busy, 0);
                check("abort_led", led, 0);
                check("abort_addr", rd_addr, 0);
                check("abort_step", step_idx, 0);
                check("abort_done", done, 0);
            end else if (abort_k > 0 && k > abort_k) begin
                check("abort_no_done", done, 0);
                check("abort_stays_idle", busy, 0);
                break;
            end else if (k < total) begin
                if (k < LEAD) begin
                    s = 0;
                    p = -1;
                end else begin
                    s = (k - LEAD) / SLOT;
                    p = (k - LEAD) % SLOT;
                end
                e_led = (p >= 1 && p <= ON) ? (4'b0001 << ref_mem[s]) : 4'b0000;
                check("play_busy", busy, 1);
                check("play_done", done, 0);
                check("play_led", led, e_led);
                check("play_addr", rd_addr, s);
                check("play_step", step_idx, s);
                if (scribble && p == 1) mem[s] = 2'($urandom);
            end else if (k == total) begin
                check("end_done", done, 1);
                check("end_busy", busy, 0);
                check("end_led", led, 0);
                if (n > 0) check("end_step", step_idx, n - 1);
            end else begin
                check("post_done", done, 0);
                check("post_busy", busy, 0);
            end
            @(negedge btn_clk);
            start = (dup_k > 0 && k + 1 == dup_k);
            abort = (abort_k > 0 && k + 1 == abort_k);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_step", step_idx, 0);
        @(negedge btn_clk);
        reset = 1'b0;

        // Three symbols {2,0,3}
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        play(3, 0, 0, 1'b0);

        // Zero length: lone done pulse
        play(0, 0, 0, 1'b0);

        // Abort during OFF of symbol 1, then a single-symbol replay
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom);
        play(3, LEAD + SLOT + ON + 2, 0, 1'b0);
        play(1, 0, 0, 1'b0);

        // Asynchronous reset mid-ON
        mem[0] = 2'd1;
        @(negedge btn_clk);
        start  = 1'b1;
        length = (AW+1)'(2);
        @(negedge btn_clk);
        start = 1'b0;
        repeat (3) @(posedge btn_clk);
        #1;
        check("pre_rst_led", led, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_addr", rd_addr, 0);
        @(negedge btn_clk);
        reset = 1'b0;
        @(posedge btn_clk);
        #1;
        check("post_rst_idle", busy, 0);
        play(1, 0, 0, 1'b0);

        // Second start while busy is ignored
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom);
        play(2, 0, 5, 1'b0);

        // start together with abort in IDLE is ignored
        @(negedge btn_clk);
        start  = 1'b1;
        abort  = 1'b1;
        length = (AW+1)'(3);
        @(posedge btn_clk);
        #1;
        check("start_abort_busy", busy, 0);
        check("start_abort_done", done, 0);
        @(negedge btn_clk);
        start = 1'b0;
        abort = 1'b0;
        @(posedge btn_clk);
        #1;
        check("start_abort_busy2", busy, 0);
        check("start_abort_done2", done, 0);

        // Length clamp to DEPTH with a cycling pattern
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'(i % 4);
        play(20, 0, 0, 1'b0);

        // Random sequences; memory is disturbed while each symbol is lit
        repeat (4) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom);
            play($urandom_range(1, 20), 0, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
